pci_target_responder: RTL and testbench



---
 rtl/pci_pkg.sv | 34 +++
 rtl/pci_target_mem.sv | 58 +++++
 rtl/pci_target_responder.sv | 211 +++++++++++++++++++++
 tb/tb_pci_target_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pci_pkg
//  Description : Shared definitions for the PCI target responder: bus command
//                codes, target FSM state encoding and the window-hit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pci_pkg;

   // Memory commands the target claims; every other command is ignored
   localparam logic [3:0] CMD_MEM_RD = 4'b0110;
   localparam logic [3:0] CMD_MEM_WR = 4'b0111;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DATA   = 3'd3,
      ST_TURN   = 3'd4,
      ST_BUSY   = 3'd5
   } pci_state_e;

   // True when addr falls inside the naturally aligned window at base;
   // mask keeps only the bits above the window size
   function automatic logic window_hit(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
      return ((addr ^ base) & mask) == 32'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pci_target_mem.sv
`default_nettype none
// ============================================================================
//  Module      : pci_target_mem
//  Description : DEPTH x 32-bit word store with per-byte write enables
//                (active-low), asynchronous clear and a combinational read.
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_target_mem
   import pci_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  logic [31:0]              wr_data,
   input  logic [3:0]               wr_be_n,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [31:0]              rd_data
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [31:0] words [DEPTH];

   for (genvar gw = 0; gw < DEPTH; gw++) begin : g_word
      logic [31:0] word_q;
      logic [31:0] word_d;

      // Merge the enabled bytes of a write into this word when it is addressed
      always_comb begin
         word_d = word_q;
         if (we && (wr_idx == IDX_W'(gw))) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
               if (!wr_be_n[b]) begin
                  word_d[8*b +: 8] = wr_data[8*b +: 8];
               end
            end
         end
      end

      // Word storage, cleared asynchronously by reset
      always_ff @(posedge clk or negedge reset_) begin
         if (!reset_) begin
            word_q <= '0;
         end else begin
            word_q <= word_d;
         end
      end

      assign words[gw] = word_q;
   end

   assign rd_data = words[rd_idx];

endmodule
`default_nettype wire

// File: rtl/pci_target_responder.sv
`default_nettype none
// ============================================================================
//  Module      : pci_target_responder
//  Description : PCI memory target. Decodes address phases against a fixed
//                window, asserts DEVSEL_/TRDY_ after programmable delays and
//                completes zero-wait read/write bursts on a word memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_target_responder
   import pci_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          DEPTH       = 16,
   parameter int          DEVSEL_DLY  = 1,
   parameter int          WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        FRAME_,
   input  logic        IRDY_,
   input  logic [3:0]  C_BE_,
   input  logic [31:0] AD_in,
   output logic [31:0] AD_out,
   output logic        AD_oe,
   output logic        DEVSEL_,
   output logic        TRDY_
);

   localparam int          IDX_W     = $clog2(DEPTH);
   localparam int          ADDR_LSB  = IDX_W + 2;
   localparam logic [31:0] WIN_MASK  = ~(32'(DEPTH) * 32'd4 - 32'd1);
   // Edge offsets (counted from the address edge) at which each output is
   // first seen asserted; reads need one extra turnaround edge at minimum
   localparam logic [3:0]  DEV_K     = 4'(DEVSEL_DLY);
   localparam logic [3:0]  TRDY_K_WR = 4'(DEVSEL_DLY + WAIT_STATES);
   localparam logic [3:0]  TRDY_K_RD = (DEVSEL_DLY + WAIT_STATES < 2) ? 4'd2 : TRDY_K_WR;

   pci_state_e        state_q,      state_d;
   logic [3:0]        cnt_q,        cnt_d;
   logic [IDX_W-1:0]  idx_q,        idx_d;
   logic              is_rd_q,      is_rd_d;
   logic              frame_prev_q, frame_prev_d;
   logic              devsel_n_q,   devsel_n_d;
   logic              trdy_n_q,     trdy_n_d;
   logic              ad_oe_q,      ad_oe_d;
   logic [31:0]       ad_out_q,     ad_out_d;

   logic              addr_edge;
   logic              cmd_rd;
   logic              cmd_wr;
   logic              hit;
   logic              rd_sel;
   logic [3:0]        next_k;
   logic [3:0]        trdy_k;
   logic              dev_due;
   logic              trdy_due;
   logic              oe_due;
   pci_state_e        launch_state;
   logic              bus_idle;
   logic              xfer;
   logic [IDX_W-1:0]  idx_inc;
   logic [IDX_W-1:0]  rd_idx;
   logic [31:0]       rd_data;

   // Address decode and the timing of the next output values
   always_comb begin
      addr_edge = (state_q == ST_IDLE) && !FRAME_ && frame_prev_q;
      cmd_rd    = (C_BE_ == CMD_MEM_RD);
      cmd_wr    = (C_BE_ == CMD_MEM_WR);
      hit       = window_hit(AD_in, BASE_ADDR, WIN_MASK) && (cmd_rd || cmd_wr);
      // next_k is the offset of the edge that will sample the new outputs
      next_k    = (state_q == ST_IDLE) ? 4'd1 : cnt_q + 4'd1;
      rd_sel    = (state_q == ST_IDLE) ? cmd_rd : is_rd_q;
      trdy_k    = rd_sel ? TRDY_K_RD : TRDY_K_WR;
      dev_due   = (next_k >= DEV_K);
      trdy_due  = (next_k >= trdy_k);
      oe_due    = rd_sel && (next_k >= 4'd2);
      if (trdy_due) begin
         launch_state = ST_DATA;
      end else if (dev_due) begin
         launch_state = ST_WAIT;
      end else begin
         launch_state = ST_DECODE;
      end
      bus_idle  = FRAME_ && IRDY_;
      xfer      = (state_q == ST_DATA) && !IRDY_ && !trdy_n_q;
      idx_inc   = idx_q + 1'b1;
      rd_idx    = xfer ? idx_inc : idx_q;
   end

   // Next-state and next-output computation for the target FSM
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      is_rd_d      = is_rd_q;
      frame_prev_d = FRAME_;
      devsel_n_d   = devsel_n_q;
      trdy_n_d     = trdy_n_q;
      ad_oe_d      = ad_oe_q;
      ad_out_d     = ad_out_q;
      case (state_q)
         ST_IDLE: begin
            if (addr_edge) begin
               idx_d   = AD_in[ADDR_LSB-1:2];
               is_rd_d = cmd_rd;
               cnt_d   = next_k;
               if (hit) begin
                  devsel_n_d = !dev_due;
                  trdy_n_d   = !trdy_due;
                  ad_oe_d    = oe_due;
                  state_d    = launch_state;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_DECODE, ST_WAIT: begin
            if (bus_idle) begin
               // Master abort: release everything and leave memory alone
               devsel_n_d = 1'b1;
               trdy_n_d   = 1'b1;
               ad_oe_d    = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               cnt_d      = next_k;
               devsel_n_d = !dev_due;
               trdy_n_d   = !trdy_due;
               ad_oe_d    = oe_due;
               state_d    = launch_state;
               if (is_rd_q) begin
                  ad_out_d = rd_data;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               idx_d = idx_inc;
               if (is_rd_q) begin
                  ad_out_d = rd_data;
               end
               if (FRAME_) begin
                  devsel_n_d = 1'b1;
                  trdy_n_d   = 1'b1;
                  ad_oe_d    = 1'b0;
                  state_d    = ST_TURN;
               end
            end
         end
         ST_TURN: begin
            state_d = ST_IDLE;
         end
         ST_BUSY: begin
            if (bus_idle) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            devsel_n_d = 1'b1;
            trdy_n_d   = 1'b1;
            ad_oe_d    = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // Target FSM state and registered bus outputs
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         is_rd_q      <= 1'b0;
         frame_prev_q <= 1'b1;
         devsel_n_q   <= 1'b1;
         trdy_n_q     <= 1'b1;
         ad_oe_q      <= 1'b0;
         ad_out_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         is_rd_q      <= is_rd_d;
         frame_prev_q <= frame_prev_d;
         devsel_n_q   <= devsel_n_d;
         trdy_n_q     <= trdy_n_d;
         ad_oe_q      <= ad_oe_d;
         ad_out_q     <= ad_out_d;
      end
   end

   pci_target_mem #(
      .DEPTH   (DEPTH)
   ) u_mem (
      .clk     (clk),
      .reset_  (reset_),
      .we      (xfer && !is_rd_q),
      .wr_idx  (idx_q),
      .wr_data (AD_in),
      .wr_be_n (C_BE_),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   assign DEVSEL_ = devsel_n_q;
   assign TRDY_   = trdy_n_q;
   assign AD_oe   = ad_oe_q;
   assign AD_out  = ad_out_q;

endmodule
`default_nettype wire

// File: tb/tb_pci_target_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pci_target_responder
//  Description : Self-checking bench for pci_target_responder. Two targets
//                (fast decode / slow decode with wait states) share the
//                master stimulus; the unselected one sees an idle bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_target_responder;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 16;

   logic        clk    = 1'b0;
   logic        reset_ = 1'b0;
   logic        frame_n = 1'b1;
   logic        irdy_n  = 1'b1;
   logic [3:0]  cbe_n   = 4'h0;
   logic [31:0] ad      = 32'h0;
   logic        sel     = 1'b0;

   logic        f0, i0, f1, i1;
   logic [31:0] ad_out0, ad_out1;
   logic        oe0, oe1, dev0, dev1, trdy0, trdy1;
   logic [31:0] obs_ad_out;
   logic        obs_oe, obs_dev, obs_trdy;

   int          n_cmp = 0;
   int          n_bad = 0;

   logic [31:0] model [0:1][0:DEPTH-1];
   logic [31:0] wdata [0:7];
   logic [3:0]  wbe   [0:7];

   assign f0 = sel ? 1'b1 : frame_n;
   assign i0 = sel ? 1'b1 : irdy_n;
   assign f1 = sel ? frame_n : 1'b1;
   assign i1 = sel ? irdy_n : 1'b1;
   assign obs_ad_out = sel ? ad_out1 : ad_out0;
   assign obs_oe     = sel ? oe1 : oe0;
   assign obs_dev    = sel ? dev1 : dev0;
   assign obs_trdy   = sel ? trdy1 : trdy0;

   pci_target_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DEVSEL_DLY(1), .WAIT_STATES(0)) dut (
      .clk(clk), .reset_(reset_), .FRAME_(f0), .IRDY_(i0), .C_BE_(cbe_n), .AD_in(ad),
      .AD_out(ad_out0), .AD_oe(oe0), .DEVSEL_(dev0), .TRDY_(trdy0));

   pci_target_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DEVSEL_DLY(2), .WAIT_STATES(3)) dut_ws (
      .clk(clk), .reset_(reset_), .FRAME_(f1), .IRDY_(i1), .C_BE_(cbe_n), .AD_in(ad),
      .AD_out(ad_out1), .AD_oe(oe1), .DEVSEL_(dev1), .TRDY_(trdy1));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Bus-level rules that must hold at every sample for both targets
   always @(negedge clk) begin
      if (reset_) begin
         if (!trdy0) check("trdy0_needs_devsel", {31'b0, dev0}, 32'd0);
         if (!trdy1) check("trdy1_needs_devsel", {31'b0, dev1}, 32'd0);
         if (oe0)    check("ad_out0_known", {31'b0, $isunknown(ad_out0)}, 32'd0);
         if (oe1)    check("ad_out1_known", {31'b0, $isunknown(ad_out1)}, 32'd0);
      end
   end

   // Edge offset from the address edge at which TRDY_ is first sampled low
   function automatic int trdy_edge(input int s, input bit rd);
      int d, w;
      d = (s != 0) ? 2 : 1;
      w = (s != 0) ? 3 : 0;
      if (rd && (d + w < 2)) return 2;
      return d + w;
   endfunction

   task automatic clear_models();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < DEPTH; i++) model[s][i] = 32'h0;
   endtask

   task automatic drive_idle();
      frame_n = 1'b1;
      irdy_n  = 1'b1;
   endtask

   // One master transaction; called at a negedge with the bus idle.
   // wait_after: word after which the master stalls 2 cycles (-1 none)
   // abort_k / rst_k: edge offset at which the master aborts / reset fires
   task automatic run_txn(input int s, input logic [31:0] addr, input logic [3:0] cmd,
                          input int nwords, input int wait_after, input int abort_k,
                          input int rst_k);
      int  dly, t, k, w, idx, waits, tail;
      bit  hit, rd, done, quit, e_dev, e_trdy, e_oe;
      sel  = s[0];
      dly  = (s != 0) ? 2 : 1;
      rd   = (cmd == 4'h6);
      hit  = (addr >= BASE) && (addr < BASE + DEPTH * 4) && (cmd == 4'h6 || cmd == 4'h7);
      t    = trdy_edge(s, rd);
      idx  = hit ? int'((addr - BASE) >> 2) : 0;
      frame_n = 1'b0;
      irdy_n  = 1'b1;
      ad      = addr;
      cbe_n   = cmd;
      @(posedge clk);
      k = 0; w = 0; waits = 0; tail = 0; done = 0; quit = 0;
      while (!quit) begin
         @(negedge clk);
         k++;
         e_dev  = hit && !done && (k >= dly);
         e_trdy = hit && !done && (k >= t);
         e_oe   = hit && rd && !done && (k >= 2);
         check($sformatf("devsel s%0d k%0d", s, k), {31'b0, obs_dev},  {31'b0, !e_dev});
         check($sformatf("trdy s%0d k%0d",   s, k), {31'b0, obs_trdy}, {31'b0, !e_trdy});
         check($sformatf("ad_oe s%0d k%0d",  s, k), {31'b0, obs_oe},   {31'b0, e_oe});
         if (e_oe) check($sformatf("ad_out s%0d idx%0d", s, idx), obs_ad_out, model[s][idx]);
         if (done) begin
            drive_idle();
            tail++;
            quit = (tail >= 2);
         end else if (!hit) begin
            if (k == 1) begin
               irdy_n  = 1'b0;
               frame_n = 1'b1;
            end else begin
               drive_idle();
            end
            quit = (k >= 4);
         end else if (k == rst_k) begin
            #2 reset_ = 1'b0;
            #1;
            check("rst_async_devsel", {31'b0, obs_dev},  32'd1);
            check("rst_async_trdy",   {31'b0, obs_trdy}, 32'd1);
            check("rst_async_oe",     {31'b0, obs_oe},   32'd0);
            check("rst_async_ad_out", obs_ad_out,        32'd0);
            clear_models();
            drive_idle();
            @(negedge clk);
            reset_ = 1'b1;
            @(negedge clk);
            quit = 1;
         end else if (k == abort_k) begin
            drive_idle();
            done = 1;
         end else if (waits > 0) begin
            irdy_n  = 1'b1;
            frame_n = 1'b0;
            waits--;
         end else begin
            irdy_n  = 1'b0;
            frame_n = (w == nwords - 1);
            ad      = rd ? $urandom : wdata[w];
            cbe_n   = rd ? 4'h0 : wbe[w];
            if (k >= t) begin
               if (!rd)
                  for (int b = 0; b < 4; b++)
                     if (!wbe[w][b]) model[s][idx][8*b +: 8] = wdata[w][8*b +: 8];
               if (w == wait_after) waits = 2;
               w++;
               idx = (idx + 1) % DEPTH;
               if (w == nwords) done = 1;
            end
         end
         if (!quit && k > 60) begin
            check("txn_cycle_bound", k, 32'd0);
            drive_idle();
            quit = 1;
         end
      end
   endtask

   logic [31:0] r_addr;
   logic [3:0]  r_cmd;
   int          r_s, r_kind, r_nw, r_wa, r_ab, r_t;

   initial begin
      clear_models();
      repeat (3) @(negedge clk);
      check("reset_devsel0", {31'b0, dev0},  32'd1);
      check("reset_trdy0",   {31'b0, trdy0}, 32'd1);
      check("reset_oe0",     {31'b0, oe0},   32'd0);
      check("reset_ad_out0", ad_out0,        32'd0);
      check("reset_devsel1", {31'b0, dev1},  32'd1);
      check("reset_oe1",     {31'b0, oe1},   32'd0);
      reset_ = 1'b1;
      @(negedge clk);

      // single write then single read back of word 2
      wdata[0] = 32'hDEAD_BEEF; wbe[0] = 4'h0;
      run_txn(0, 32'h0000_1008, 4'h7, 1, -1, -1, -1);
      run_txn(0, 32'h0000_1008, 4'h6, 1, -1, -1, -1);

      // burst write wrapping 15->0->1->2, low half-words only, then read back
      for (int i = 0; i < 4; i++) begin wdata[i] = $urandom; wbe[i] = 4'hC; end
      run_txn(0, 32'h0000_103C, 4'h7, 4, -1, -1, -1);
      run_txn(0, 32'h0000_103C, 4'h6, 4, -1, -1, -1);

      // misses: outside the window on both sides, and a non-memory command
      run_txn(0, 32'h0000_2000, 4'h7, 1, -1, -1, -1);
      run_txn(0, 32'h0000_1040, 4'h6, 1, -1, -1, -1);
      run_txn(0, 32'h0000_0FFC, 4'h7, 1, -1, -1, -1);
      run_txn(0, 32'h0000_1008, 4'h2, 1, -1, -1, -1);

      // master abort on the slow target, then confirm word 4 untouched
      wdata[0] = 32'h1234_5678; wbe[0] = 4'h0;
      run_txn(1, 32'h0000_1010, 4'h7, 1, -1, 1, -1);
      run_txn(1, 32'h0000_1010, 4'h6, 1, -1, -1, -1);

      // slow-target burst write and read with master wait states
      for (int i = 0; i < 3; i++) begin wdata[i] = $urandom; wbe[i] = 4'h0; end
      run_txn(1, 32'h0000_1020, 4'h7, 3, 0, -1, -1);
      run_txn(1, 32'h0000_1020, 4'h6, 3, 1, -1, -1);

      // fast-target read burst with a 2-cycle master stall mid-burst
      run_txn(0, 32'h0000_1038, 4'h6, 4, 1, -1, -1);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         r_s    = $urandom_range(0, 1);
         r_kind = $urandom_range(0, 9);
         r_addr = BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
         r_cmd  = ($urandom_range(0, 1) != 0) ? 4'h7 : 4'h6;
         if (r_kind == 0) r_addr = 32'h0000_4000 + $urandom_range(0, 255);
         if (r_kind == 1) r_cmd  = 4'h2;
         r_nw = $urandom_range(1, 5);
         r_wa = (r_nw > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(0, r_nw - 2) : -1;
         r_ab = -1;
         r_t  = trdy_edge(r_s, r_cmd == 4'h6);
         if (r_kind == 2 && r_t > 1) r_ab = $urandom_range(1, r_t - 1);
         for (int i = 0; i < r_nw; i++) begin
            wdata[i] = $urandom;
            wbe[i]   = 4'($urandom_range(0, 15));
         end
         run_txn(r_s, r_addr, r_cmd, r_nw, r_wa, r_ab, -1);
      end

      // make sure word 2 holds data before resetting mid-burst
      wdata[0] = 32'hCAFE_F00D; wbe[0] = 4'h0;
      run_txn(0, 32'h0000_1008, 4'h7, 1, -1, -1, -1);
      run_txn(0, 32'h0000_1000, 4'h6, 6, -1, -1, 4);
      run_txn(0, 32'h0000_1008, 4'h6, 1, -1, -1, -1);
      run_txn(1, 32'h0000_1008, 4'h6, 2, -1, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
